// File: rtl/arg_issuer_pkg.sv
// rtl/arg_issuer_pkg.sv - shared state encoding and default sizes for the argument issuer
package arg_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RES = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    localparam int ARG_W_DEF   = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 100;
    localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/arg_fifo.sv
// rtl/arg_fifo.sv - power-of-two argument queue; push is ignored while full, pop while empty
module arg_fifo
    import arg_issuer_pkg::*;
#(
    parameter int W     = ARG_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // Fullness is judged before the edge, so a full queue never accepts even when popping.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/arg_issuer.sv
// rtl/arg_issuer.sv - queues arguments and issues them over a four-phase stb/ack/res handshake
// Optional watchdog abort enabled by defining ARG_ISSUER_WATCHDOG_EN.
module arg_issuer
    import arg_issuer_pkg::*;
#(
    parameter int W       = ARG_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic [W-1:0]         arg,
    output logic                 arg_stb,
    input  logic                 arg_ack,
    input  logic                 res_stb,
    output logic                 done,
    output logic                 timeout,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_e       state_q, state_d;
    logic [W-1:0] arg_q, arg_d;
    logic         stb_q, stb_d;
    logic         done_q, done_d;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic [W-1:0] fifo_head;

    arg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

`ifdef ARG_ISSUER_WATCHDOG_EN
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 timeout_q, wd_d;
    logic                 wd_expired;

    assign wd_expired = (timer_q == TIMER_W'(TIMEOUT));

    // The timer spans the whole request (REQ and WAIT_RES) and restarts for each argument.
    always_comb begin
        timer_d = '0;
        if ((state_q == REQ || state_q == WAIT_RES) &&
            (state_d == REQ || state_d == WAIT_RES)) begin
            timer_d = timer_q + 1'b1;
        end
        err_d = err_q;
        if (wd_d && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            err_q     <= err_d;
            timeout_q <= wd_d;
        end
    end

    assign timeout = timeout_q;
    assign err_cnt = err_q;
`else
    assign timeout = 1'b0;
    assign err_cnt = '0;
`endif

    // A result always beats a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        stb_d   = stb_q;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef ARG_ISSUER_WATCHDOG_EN
        wd_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    arg_d   = fifo_head;
                    stb_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (arg_ack && res_stb) begin
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = RELEASE;
`ifdef ARG_ISSUER_WATCHDOG_EN
                end else if (wd_expired) begin
                    stb_d   = 1'b0;
                    wd_d    = 1'b1;
                    state_d = RELEASE;
`endif
                end else if (arg_ack) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_stb) begin
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = RELEASE;
`ifdef ARG_ISSUER_WATCHDOG_EN
                end else if (wd_expired) begin
                    stb_d   = 1'b0;
                    wd_d    = 1'b1;
                    state_d = RELEASE;
`endif
                end
            end
            RELEASE: begin
                if (!arg_ack && !res_stb) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            arg_q   <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = !fifo_full;
    assign arg      = arg_q;
    assign arg_stb  = stb_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_arg_issuer.sv
// tb/tb_arg_issuer.sv - directed-vector bench for arg_issuer (watchdog cases when ARG_ISSUER_WATCHDOG_EN is defined)
module tb_arg_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] arg;
    logic        arg_stb;
    logic        arg_ack;
    logic        res_stb;
    logic        done;
    logic        timeout;
    logic        busy;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int tmo_cnt     = 0;
    int d0;
    int t0;

    arg_issuer #(.W(32), .DEPTH(4), .TIMEOUT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .arg      (arg),
        .arg_stb  (arg_stb),
        .arg_ack  (arg_ack),
        .res_stb  (res_stb),
        .done     (done),
        .timeout  (timeout),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    done_cnt++;
        if (timeout) tmo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_stb();
        int n = 0;
        while (!arg_stb && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stb_wait", {31'd0, arg_stb}, 32'd1);
    endtask

    // Serve one argument; returns one cycle after done, with res_stb low and arg_ack still high.
    task automatic complete(input logic [31:0] exp, input int ack_dly, input int res_dly);
        wait_stb();
        check("arg", arg, exp);
        repeat (ack_dly) begin
            @(negedge clk);
            check("arg_hold_req", arg, exp);
        end
        arg_ack = 1'b1;
        repeat (res_dly) begin
            @(negedge clk);
            check("arg_hold_wait", arg, exp);
            check("stb_hold_wait", {31'd0, arg_stb}, 32'd1);
        end
        res_stb = 1'b1;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("stb_drop", {31'd0, arg_stb}, 32'd0);
        check("no_timeout", {31'd0, timeout}, 32'd0);
        res_stb = 1'b0;
    endtask

    task automatic release_ack(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check("release_hold", {31'd0, arg_stb}, 32'd0);
        end
        arg_ack = 1'b0;
        @(negedge clk);
        check("spacing", {31'd0, arg_stb}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        arg_ack  = 1'b0;
        res_stb  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stb", {31'd0, arg_stb}, 32'd0);
        check("rst_arg", arg, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single argument: ack one cycle after stb, result two cycles after ack
        d0 = done_cnt;
        push_one(32'h5);
        check("lat_stb_low", {31'd0, arg_stb}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_stb_high", {31'd0, arg_stb}, 32'd1);
        complete(32'h5, 1, 2);
        release_ack(0);
        check("single_done_cnt", done_cnt - d0, 32'd1);
        check("single_err_cnt", {24'd0, err_cnt}, 32'd0);

        // ack and result together from REQ, ack then held 3 cycles while the queue fills
        d0 = done_cnt;
        push_one(32'h7);
        complete(32'h7, 0, 0);
        for (int i = 1; i <= 4; i++) push_one(i);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'h5;
        repeat (3) begin
            @(negedge clk);
            check("full_hold_ready", {31'd0, in_ready}, 32'd0);
            check("ack_hold_stb", {31'd0, arg_stb}, 32'd0);
        end
        fork
            begin
                push_one(32'h5);
                push_one(32'h6);
            end
            begin
                release_ack(0);
                for (int k = 1; k <= 6; k++) begin
                    complete(k, k % 3, (k % 2 == 1) ? 1 : 0);
                    release_ack(0);
                end
            end
        join
        check("burst_done_cnt", done_cnt - d0, 32'd7);
        check("burst_idle_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset while in WAIT_RES with two entries queued
        push_one(32'h11);
        push_one(32'h12);
        push_one(32'h13);
        wait_stb();
        check("pre_rst_arg", arg, 32'h11);
        arg_ack = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        t0 = tmo_cnt;
        #2 rst = 1'b1;
        #1;
        check("arst_stb", {31'd0, arg_stb}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_arg", arg, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        arg_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_no_issue", {31'd0, arg_stb}, 32'd0);
        check("arst_no_done", done_cnt - d0, 32'd0);
        check("arst_no_tmo", tmo_cnt - t0, 32'd0);
        push_one(32'h21);
        complete(32'h21, 2, 1);
        release_ack(1);

`ifdef ARG_ISSUER_WATCHDOG_EN
        begin
            int n;
            // downstream never acks 0xA: stb high for 101 cycles, then abort
            d0 = done_cnt;
            push_one(32'hA);
            push_one(32'hB);
            wait_stb();
            check("wd_arg", arg, 32'hA);
            n = 0;
            while (arg_stb && n < 300) begin
                n++;
                @(negedge clk);
            end
            check("wd_stb_cycles", n, 32'd101);
            check("wd_timeout", {31'd0, timeout}, 32'd1);
            check("wd_err_cnt", {24'd0, err_cnt}, 32'd1);
            @(negedge clk);
            check("wd_pulse_end", {31'd0, timeout}, 32'd0);
            check("wd_no_done", done_cnt - d0, 32'd0);
            complete(32'hB, 1, 1);
            release_ack(0);

            // result sampled in the same cycle the timer reaches TIMEOUT
            push_one(32'hC);
            wait_stb();
            arg_ack = 1'b1;
            repeat (100) @(negedge clk);
            res_stb = 1'b1;
            @(negedge clk);
            check("race_done", {31'd0, done}, 32'd1);
            check("race_timeout", {31'd0, timeout}, 32'd0);
            check("race_err_cnt", {24'd0, err_cnt}, 32'd1);
            res_stb = 1'b0;
            release_ack(0);
        end
`else
        check("nowd_timeout", {31'd0, timeout}, 32'd0);
        check("nowd_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("nowd_tmo_cnt", tmo_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arg_issuer.md
ARG_ISSUER -- requirements
Module: arg_issuer

Interface
REQ-001 SHALL have parameter W, default 32, width of argument word.
REQ-002 SHALL have parameter DEPTH, default 4, argument queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 100, watchdog limit in clk cycles.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  upstream argument present.
REQ-007 SHALL have port in_data  in  W  upstream argument.
REQ-008 SHALL have port in_ready  out  1  queue not full; transfer when in_valid&&in_ready.
REQ-009 SHALL have port arg  out  W  argument to downstream unit, registered.
REQ-010 SHALL have port arg_stb  out  1  request strobe to downstream unit.
REQ-011 SHALL have port arg_ack  in  1  downstream accepted argument.
REQ-012 SHALL have port res_stb  in  1  downstream result ready.
REQ-013 SHALL have port done  out  1  one-cycle pulse, transaction completed normally.
REQ-014 SHALL have port timeout  out  1  one-cycle pulse, transaction aborted by watchdog.
REQ-015 SHALL have port busy  out  1  FSM not IDLE or queue not empty.
REQ-016 SHALL have port err_cnt  out  8  timeouts since reset, saturating at 255.

Function
REQ-017 SHALL queue arguments in a DEPTH-entry FIFO; in_ready = !full; no write when full.
REQ-018 SHALL allow FIFO push and pop in the same cycle, count unchanged, including when full (in_ready stays 0 when full; push only if not full before edge).
REQ-019 SHALL run FSM IDLE -> REQ -> WAIT_RES -> RELEASE -> IDLE.
REQ-020 IDLE: if FIFO non-empty, pop head into arg, set arg_stb=1, go REQ; else hold.
REQ-021 REQ: arg_stb=1; on arg_ack=1 go WAIT_RES.
REQ-022 WAIT_RES: arg_stb=1; on res_stb=1 set arg_stb=0, pulse done next cycle, go RELEASE.
REQ-023 REQ sampling arg_ack=1 and res_stb=1 together SHALL go directly to RELEASE with done.
REQ-024 RELEASE: arg_stb=0; go IDLE when arg_ack=0 and res_stb=0 (four-phase completion).
REQ-025 arg SHALL stay stable whenever arg_stb=1.
REQ-026 Latency: argument accepted at edge N into empty queue with FSM IDLE -> arg_stb=1 after edge N+1.
REQ-027 Minimum spacing: next arg_stb rise no earlier than one cycle after arg_ack/res_stb both low.

Reset
REQ-028 rst=1 SHALL immediately clear: FIFO empty, FSM IDLE, arg=0, arg_stb=0, done=0, timeout=0, err_cnt=0, watchdog timer=0; in_ready=1, busy=0.
REQ-029 Reset mid-transaction SHALL drop arg_stb without done/timeout pulse and discard queued entries.

Configuration
REQ-030 ARG_ISSUER_WATCHDOG_EN defined: timer increments each cycle in REQ/WAIT_RES, clears elsewhere; when timer == TIMEOUT, SHALL drop arg_stb, pulse timeout, increment err_cnt, go RELEASE.
REQ-031 Timeout and res_stb in same cycle: res_stb wins, done pulses, no timeout.
REQ-032 ARG_ISSUER_WATCHDOG_EN undefined: no timer logic; timeout tied 0, err_cnt tied 0; FSM waits indefinitely.

Structure
REQ-033 Package arg_issuer_pkg SHALL hold state enum (IDLE, REQ, WAIT_RES, RELEASE), default W/DEPTH/TIMEOUT constants, err_cnt width.
REQ-034 FIFO SHALL be sub-module arg_fifo (W, DEPTH; push/pop/full/empty/head); FSM and watchdog in arg_issuer.

Verification
REQ-035 Single arg 0x5, downstream acks 1 cycle after stb, res_stb 2 cycles later -> arg=0x5 stable, one done pulse, err_cnt=0.
REQ-036 Push 0x1..0x6 back-to-back, DEPTH=4, downstream stalled -> in_ready low after 4 accepted (5th held by in_valid), all six issued in order, six done pulses.
REQ-037 Watchdog on, TIMEOUT=100, downstream never acks arg 0xA -> arg_stb drops, timeout pulse at timer 100, err_cnt=1, next queued arg issued.
REQ-038 res_stb arriving same cycle as timer==TIMEOUT -> done=1, timeout=0, err_cnt unchanged.
REQ-039 rst pulsed while in WAIT_RES with 2 queued -> arg_stb=0 asynchronously, busy=0, no done/timeout, subsequent push issues normally.
REQ-040 Downstream holds arg_ack high 3 cycles after res_stb -> FSM stays RELEASE, next arg_stb only after ack low.
